// File: rtl/lif_neuron_array.sv
// Time-multiplexed two-compartment LIF neuron array, one neuron per clock.
// Optional spike counter enabled by defining LIF_SPIKE_COUNT_EN.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int DATA_W    = 16,
  parameter int LEAK      = 1,
  parameter int V_THRESH  = 10,
  parameter int G_C       = 1,
  parameter int REFRAC    = 2,
  parameter int IDX_W     =
    (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic                     state_clr,
  output logic [IDX_W-1:0]         syn_idx,
  input  logic signed [DATA_W-1:0] syn_in,
  output logic                     spike_valid,
  output logic [IDX_W-1:0]         spike_idx,
  output logic                     done,
  output logic [IDX_W:0]           spike_count
);

  localparam int AW = DATA_W + 2;
  localparam int CW = IDX_W + 1;
  localparam int RW =
    (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_NEURONS - 1);
  localparam logic [DATA_W-1:0] VMAX_D =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] VMAX =
    {2'b00, VMAX_D};
  localparam logic signed [AW-1:0] LEAK_A =
    AW'(LEAK);
  localparam logic signed [AW-1:0] THR_A =
    AW'(V_THRESH);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_spike_valid;
  logic [IDX_W-1:0]  r_spike_idx;
  logic              r_done;

  logic [DATA_W-1:0] r_vs  [N_NEURONS];
  logic [DATA_W-1:0] r_vd  [N_NEURONS];
  logic [RW-1:0]     r_ref [N_NEURONS];

  logic                     w_refr;
  logic signed [AW-1:0]     w_vd;
  logic signed [AW-1:0]     w_vs;
  logic signed [AW-1:0]     w_syn;
  logic signed [AW-1:0]     w_diff;
  logic signed [AW-1:0]     w_c;
  logic signed [AW-1:0]     w_vd_n;
  logic signed [AW-1:0]     w_vs_n;
  logic [DATA_W-1:0]        w_vd_cl;
  logic [DATA_W-1:0]        w_vs_cl;
  logic                     w_fire;

  function automatic logic [DATA_W-1:0] clamp(
    input logic signed [AW-1:0] v
  );
    if (v < 0)
      return '0;
    else if (v > VMAX)
      return VMAX_D;
    else
      return v[DATA_W-1:0];
  endfunction

  // A refractory soma reads as zero so coupling drains the dendrite.
  assign w_refr = (r_ref[r_idx] != '0);
  assign w_vd   = $signed({2'b00, r_vd[r_idx]});
  assign w_vs   = w_refr ? '0
                : $signed({2'b00, r_vs[r_idx]});
  assign w_syn  = {{2{syn_in[DATA_W-1]}}, syn_in};
  assign w_diff = w_vd - w_vs;
  assign w_c    = w_diff >>> G_C;
  assign w_vd_n = w_vd + w_syn - LEAK_A - w_c;
  assign w_vs_n = w_vs + w_c - LEAK_A;
  assign w_vd_cl = clamp(w_vd_n);
  assign w_vs_cl = clamp(w_vs_n);
  assign w_fire = !w_refr &&
    ($signed({2'b00, w_vs_cl}) >= THR_A);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
      r_done        <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_vs[i]  <= '0;
        r_vd[i]  <= '0;
        r_ref[i] <= '0;
      end
    end else begin
      r_spike_valid <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (state_clr) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              r_vs[i]  <= '0;
              r_vd[i]  <= '0;
              r_ref[i] <= '0;
            end
          end
          if (step_valid)
            r_state <= S_RUN;
        end
        S_RUN: begin
          r_vd[r_idx] <= w_vd_cl;
          r_vs[r_idx] <= (w_refr || w_fire) ? '0
                       : w_vs_cl;
          if (w_refr)
            r_ref[r_idx] <= r_ref[r_idx] - RW'(1);
          else if (w_fire)
            r_ref[r_idx] <= RW'(REFRAC);
          r_spike_valid <= w_fire;
          if (w_fire)
            r_spike_idx <= r_idx;
          if (r_idx == LAST) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign step_ready  = (r_state == S_IDLE);
  assign syn_idx     = r_idx;
  assign spike_valid = r_spike_valid;
  assign spike_idx   = r_spike_idx;
  assign done        = r_done;

`ifdef LIF_SPIKE_COUNT_EN
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_spike_count;

  // Last neuron's spike is folded in as the total is published.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_spike_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (step_valid)
        r_cnt <= '0;
    end else begin
      if (r_idx == LAST)
        r_spike_count <= r_cnt + CW'(w_fire);
      else if (w_fire)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign spike_count = r_spike_count;
`else
  assign spike_count = CW'(0);
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array (N=4, default parameters).
// Hand-computed vectors; internal membranes observed hierarchically.
module tb_lif_neuron_array;

  localparam int N = 4;

  logic              clk;
  logic              rst;
  logic              step_valid;
  logic              step_ready;
  logic              state_clr;
  logic [1:0]        syn_idx;
  logic signed [15:0] syn_val;
  logic              spike_valid;
  logic [1:0]        spike_idx;
  logic              done;
  logic [2:0]        spike_count;

  int n_checks;
  int n_errors;

  logic [3:0] s_mask;
  int         s_done_k;
  logic [2:0] s_cnt;

  lif_neuron_array dut (
    .clk         (clk),
    .rst         (rst),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .state_clr   (state_clr),
    .syn_idx     (syn_idx),
    .syn_in      (syn_val),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
    .done        (done),
    .spike_count (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef LIF_SPIKE_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int b;
    b = 0;
    while (!step_ready && b < 50) begin
      tick();
      b++;
    end
    chk("ready", step_ready, 1);
  endtask

  task automatic run_step(
    input logic signed [15:0] syn,
    input logic               clr
  );
    wait_ready();
    syn_val    = syn;
    state_clr  = clr;
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    state_clr  = 1'b0;
    s_mask     = '0;
    s_done_k   = 0;
    s_cnt      = '0;
    for (int k = 1; k <= N + 2; k++) begin
      if (k <= N)
        chk("syn_idx", syn_idx, k - 1);
      if (spike_valid) begin
        chk("spk_slot", spike_idx, k - 2);
        s_mask[spike_idx] = 1'b1;
      end
      if (done) begin
        s_done_k = k;
        s_cnt    = spike_count;
      end
      tick();
    end
  endtask

  task automatic clear_state();
    wait_ready();
    state_clr = 1'b1;
    tick();
    state_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int dk [3];
    int q;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    step_valid = 1'b0;
    state_clr  = 1'b0;
    syn_val    = '0;

    #23;
    chk("rst_ready", step_ready, 1);
    chk("rst_spk", spike_valid, 0);
    chk("rst_sidx", spike_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", spike_count, 0);
    chk("rst_synidx", syn_idx, 0);
    chk("rst_vd0", dut.r_vd[0], 0);
    tick();
    rst = 1'b1;
    tick();

    run_step(16'sd20, 1'b0);
    chk("s1_vd0", dut.r_vd[0], 19);
    chk("s1_vs0", dut.r_vs[0], 0);
    chk("s1_mask", s_mask, 0);
    chk("s1_done", s_done_k, N + 1);
    run_step(16'sd20, 1'b0);
    chk("s2_vd0", dut.r_vd[0], 29);
    chk("s2_vs0", dut.r_vs[0], 8);
    chk("s2_mask", s_mask, 0);
    run_step(16'sd20, 1'b0);
    chk("s3_mask", s_mask, 4'hF);
    chk("s3_done", s_done_k, N + 1);
    chk("s3_cnt", s_cnt, exp_cnt(4));
    chk("s3_vd0", dut.r_vd[0], 38);
    chk("s3_vs0", dut.r_vs[0], 0);
    chk("s3_ref0", dut.r_ref[0], 2);
    run_step(16'sd20, 1'b0);
    chk("s4_mask", s_mask, 0);
    chk("s4_vd0", dut.r_vd[0], 38);
    chk("s4_vs0", dut.r_vs[0], 0);
    chk("s4_cnt", s_cnt, exp_cnt(0));
    run_step(16'sd20, 1'b0);
    chk("s5_mask", s_mask, 0);
    chk("s5_ref3", dut.r_ref[3], 0);
    run_step(16'sd20, 1'b0);
    chk("s6_mask", s_mask, 4'hF);

    clear_state();
    chk("clr_vd0", dut.r_vd[0], 0);
    chk("clr_vd3", dut.r_vd[3], 0);
    chk("clr_ref2", dut.r_ref[2], 0);
    run_step(16'sd20, 1'b0);
    run_step(16'sd20, 1'b1);
    chk("clrstep_vd0", dut.r_vd[0], 19);
    chk("clrstep_vs1", dut.r_vs[1], 0);

    clear_state();
    run_step(16'sd0, 1'b0);
    chk("zero_mask", s_mask, 0);
    chk("zero_done", s_done_k, N + 1);
    chk("zero_vd2", dut.r_vd[2], 0);
    run_step(-16'sd5, 1'b0);
    chk("neg_vd0", dut.r_vd[0], 0);
    chk("neg_vs0", dut.r_vs[0], 0);
    chk("neg_mask", s_mask, 0);

    run_step(16'sd32767, 1'b1);
    chk("sat1_vd0", dut.r_vd[0], 32766);
    run_step(16'sd32767, 1'b0);
    chk("sat2_vd0", dut.r_vd[0], 32767);
    chk("sat2_mask", s_mask, 4'hF);
    run_step(16'sd32767, 1'b0);
    chk("sat3_vd3", dut.r_vd[3], 32767);
    chk("sat3_mask", s_mask, 0);

    clear_state();
    syn_val    = '0;
    step_valid = 1'b1;
    nd = 0;
    for (int k = 0; k < 3; k++) dk[k] = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (done) begin
        if (nd < 3) dk[nd] = k;
        nd++;
      end
    end
    step_valid = 1'b0;
    chk("bb_ndone", nd, 3);
    chk("bb_done0", dk[0], 5);
    chk("bb_done1", dk[1], 10);
    chk("bb_done2", dk[2], 15);

    clear_state();
    run_step(16'sd20, 1'b0);
    run_step(16'sd20, 1'b0);
    wait_ready();
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_spk", spike_valid, 1);
    chk("pre_rst_sidx", spike_idx, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_spk", spike_valid, 0);
    chk("mid_rst_sidx", spike_idx, 0);
    chk("mid_rst_synidx", syn_idx, 0);
    chk("mid_rst_ready", step_ready, 1);
    chk("mid_rst_vd0", dut.r_vd[0], 0);
    tick();
    rst = 1'b1;
    q = 0;
    for (int k = 0; k < 8; k++) begin
      if (spike_valid || done) q++;
      tick();
    end
    chk("post_rst_quiet", q, 0);
    run_step(16'sd20, 1'b0);
    chk("post_rst_vd0", dut.r_vd[0], 19);
    chk("post_rst_mask", s_mask, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
